// File: rtl/sqrt_request_scheduler_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : sqrt_request_scheduler_pkg
// Purpose : Shared types and default constants for the square-root request
//           scheduler (FSM state encoding, default parameters, index helper).
// Ports   : none (package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package sqrt_request_scheduler_pkg;

    localparam int c_DEF_N_REQ   = 4;
    localparam int c_DEF_DATA_W  = 8;
    localparam int c_DEF_RES_W   = 4;
    localparam int c_DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } sched_state_t;

    // Next index after idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : sqrt_request_scheduler_pkg
`default_nettype wire

// File: rtl/sqrt_request_scheduler_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : sqrt_request_scheduler_if
// Purpose : Bundles the client request/response handshake and the sqrt-unit
//           Start/Done handshake seen by the scheduler.
// Ports   : master - client/sqrt-unit side (drives req, req_data, resp_ready,
//                    sqrt_done, sqrt_result)
//           slave  - scheduler side (drives gnt, resp_*, sqrt_start,
//                    sqrt_operand, sqrt_clr)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface sqrt_request_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int RES_W  = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [ID_W-1:0]         resp_id;
    logic [RES_W-1:0]        resp_data;
    logic                    resp_err;
    logic                    sqrt_start;
    logic [DATA_W-1:0]       sqrt_operand;
    logic                    sqrt_clr;
    logic                    sqrt_done;
    logic [RES_W-1:0]        sqrt_result;

    modport master (
        output req, req_data, resp_ready, sqrt_done, sqrt_result,
        input  gnt, resp_valid, resp_id, resp_data, resp_err,
               sqrt_start, sqrt_operand, sqrt_clr
    );

    modport slave (
        input  req, req_data, resp_ready, sqrt_done, sqrt_result,
        output gnt, resp_valid, resp_id, resp_data, resp_err,
               sqrt_start, sqrt_operand, sqrt_clr
    );

endinterface : sqrt_request_scheduler_if
`default_nettype wire

// File: rtl/sqrt_request_scheduler_rr_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rr_arbiter
// Purpose : Combinational round-robin pick: first set request bit scanning
//           ptr_i, ptr_i+1, ... modulo N.
// Ports   : req_i   [N]     request vector
//           ptr_i   [IDX_W] highest-priority index
//           grant_o [N]     one-hot winner (zero when no request)
//           idx_o   [IDX_W] winner index
//           any_o           at least one request present
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                any_o         = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/sqrt_request_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : sqrt_request_scheduler
// Purpose : Shares one square-root unit among N_REQ clients. Round-robin
//           grant, operand capture, Start launch, Done wait guarded by a
//           watchdog, and result return over a valid/ready handshake.
// Ports   : clk   - rising-edge clock
//           CLR   - synchronous active-high reset
//           bus   - slave view of sqrt_request_scheduler_if (client and
//                   sqrt-unit handshakes)
//           busy  - high whenever a job is in flight (state != IDLE)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module sqrt_request_scheduler
    import sqrt_request_scheduler_pkg::*;
#(
    parameter int N_REQ   = c_DEF_N_REQ,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int RES_W   = c_DEF_RES_W,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     CLR,
    sqrt_request_scheduler_if.slave  bus,
    output logic                     busy
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    sched_state_t      state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] operand_q;
    logic [RES_W-1:0]  result_q;
    logic              err_q;
    logic              sclr_q;
    logic [WD_W-1:0]   wdog_q;

    logic [N_REQ-1:0]  w_arb_grant;
    logic [ID_W-1:0]   w_arb_idx;
    logic              w_arb_any;
    logic              w_grant_en;
    logic              w_timeout;
    logic [DATA_W-1:0] w_sel_operand;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .grant_o (w_arb_grant),
        .idx_o   (w_arb_idx),
        .any_o   (w_arb_any)
    );

    // Grants are suppressed during CLR so a client never drops its request
    // for a job that the reset is about to discard.
    assign w_grant_en = (state_q == IDLE) && !CLR;
    assign w_timeout  = (wdog_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        w_sel_operand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_arb_idx == ID_W'(i)) begin
                w_sel_operand = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_arb_any)                      state_d = LAUNCH;
            LAUNCH:                                      state_d = WAIT;
            WAIT:    if (bus.sqrt_done || w_timeout)     state_d = RESP;
            RESP:    if (bus.resp_ready)                 state_d = IDLE;
            default:                                     state_d = IDLE;
        endcase
    end

    // Job registers and watchdog
    always_ff @(posedge clk) begin
        if (CLR) begin
            ptr_q     <= '0;
            id_q      <= '0;
            operand_q <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            sclr_q    <= 1'b0;
            wdog_q    <= '0;
        end else begin
            sclr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_arb_any) begin
                        operand_q <= w_sel_operand;
                        id_q      <= w_arb_idx;
                    end
                end
                LAUNCH: begin
                    wdog_q <= '0;
                end
                WAIT: begin
                    // Done takes priority over an expiring watchdog.
                    if (bus.sqrt_done) begin
                        result_q <= bus.sqrt_result;
                        err_q    <= 1'b0;
                    end else if (w_timeout) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        sclr_q   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        ptr_q <= ID_W'(wrap_inc(int'(id_q), N_REQ));
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt          = w_grant_en ? w_arb_grant : '0;
    assign bus.sqrt_start   = (state_q == LAUNCH);
    assign bus.sqrt_operand = operand_q;
    assign bus.sqrt_clr     = sclr_q;
    assign bus.resp_valid   = (state_q == RESP);
    assign bus.resp_id      = id_q;
    assign bus.resp_data    = result_q;
    assign bus.resp_err     = err_q;
    assign busy             = (state_q != IDLE);

endmodule : sqrt_request_scheduler
`default_nettype wire
